// File: rtl/fadd_rr_sched_if.sv
// Request/response bundle between FP engines and the shared-adder scheduler.
// master = engines + result consumer, slave = fadd_rr_sched.
interface fadd_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [ID_W-1:0]       resp_id;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/fadd_rr_sched.sv
// Round-robin share of one combinational fadd_ieee754; 2 cycles accept->resp, req_ready low when both
// stages are full and resp_ready is low. Defining FADD_SCHED_STATS_EN adds a saturating op_count port.
module fadd_ieee754 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic        swap, sub, sl;
    logic [7:0]  el_raw, es_raw, el, es, dexp, lim, sh;
    logic [26:0] ml, ms, ms_sh, ms_al, mn;
    logic [27:0] raw;
    logic [4:0]  lz;
    logic [9:0]  en;
    logic        stk, rnd;
    logic [30:0] mag_r;
    logic        a_inf, b_inf, a_nan, b_nan;

    always_comb begin
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        swap   = b[30:0] > a[30:0];
        sl     = swap ? b[31] : a[31];
        sub    = a[31] ^ b[31];
        el_raw = swap ? b[30:23] : a[30:23];
        es_raw = swap ? a[30:23] : b[30:23];
        el     = (el_raw == 8'd0) ? 8'd1 : el_raw;
        es     = (es_raw == 8'd0) ? 8'd1 : es_raw;
        ml     = {(el_raw != 8'd0), (swap ? b[22:0] : a[22:0]), 3'b000};
        ms     = {(es_raw != 8'd0), (swap ? a[22:0] : b[22:0]), 3'b000};
        dexp   = el - es;
        // Bits shifted past the guard/round positions collapse into the sticky bit.
        if (dexp >= 8'd27) begin
            ms_sh = '0;
            stk   = |ms;
        end else begin
            ms_sh = ms >> dexp;
            stk   = |(ms & ~(27'h7FFFFFF << dexp));
        end
        ms_al = {ms_sh[26:1], ms_sh[0] | stk};
        raw   = sub ? ({1'b0, ml} - {1'b0, ms_al}) : ({1'b0, ml} + {1'b0, ms_al});
        lz    = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (raw[i]) lz = 5'(26 - i);
        end
        // Left normalisation stops at exponent 1 so tiny results come out subnormal.
        lim = el - 8'd1;
        sh  = ({3'b000, lz} > lim) ? lim : {3'b000, lz};
        if (raw[27]) begin
            mn = {raw[27:2], raw[1] | raw[0]};
            en = {2'b00, el} + 10'd1;
        end else begin
            mn = raw[26:0] << sh;
            en = {2'b00, el} - {2'b00, sh};
        end
        rnd   = mn[2] & (mn[1] | mn[0] | mn[3]);
        // Rounding carry ripples from the fraction into the exponent field.
        mag_r = {(mn[26] ? en[7:0] : 8'd0), mn[25:3]} + {30'd0, rnd};
        if (a_nan || b_nan || (a_inf && b_inf && sub)) begin
            sum = 32'h7FC00000;
        end else if (a_inf) begin
            sum = a;
        end else if (b_inf) begin
            sum = b;
        end else if (raw == 28'd0) begin
            sum = {(sub ? 1'b0 : sl), 31'd0};
        end else if (en >= 10'd255) begin
            sum = {sl, 8'hFF, 23'd0};
        end else begin
            sum = {sl, mag_r};
        end
    end
endmodule

module fadd_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic clk,
    input  logic rst,
    fadd_rr_sched_if.slave bus
`ifdef FADD_SCHED_STATS_EN
    ,
    output logic [15:0] op_count
`endif
);
    typedef struct packed {
        logic [31:0]     a;
        logic [31:0]     b;
        logic [ID_W-1:0] id;
    } s1_t;

    typedef struct packed {
        logic [31:0]     sum;
        logic [ID_W-1:0] id;
    } s2_t;

    s1_t                s1;
    s2_t                s2;
    logic               s1_v, s2_v;
    logic [ID_W-1:0]    rr_last;
    logic               s2_adv, s1_adv, s1_free, accept, found;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic [31:0]        sel_a, sel_b, add_sum;
    int                 idx;

    assign s2_adv  = !s2_v || bus.resp_ready;
    assign s1_adv  = s1_v && s2_adv;
    assign s1_free = !s1_v || s1_adv;

    // Scan starts just after the last winner; operands only steer the data path.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        gnt_id = '0;
        sel_a  = '0;
        sel_b  = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_last) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = ID_W'(idx);
                sel_a      = bus.req_a[32*idx +: 32];
                sel_b      = bus.req_b[32*idx +: 32];
            end
        end
    end

    assign bus.req_ready  = s1_free ? grant : '0;
    assign accept         = s1_free && found;
    assign bus.resp_valid = s2_v;
    assign bus.resp_data  = s2.sum;
    assign bus.resp_id    = s2.id;

    fadd_ieee754 u_fadd (
        .a   (s1.a),
        .b   (s1.b),
        .sum (add_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            rr_last <= ID_W'(NUM_REQ - 1);
        end else begin
            if (accept) begin
                s1      <= {sel_a, sel_b, gnt_id};
                s1_v    <= 1'b1;
                rr_last <= gnt_id;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
            if (s1_adv) begin
                s2   <= {add_sum, s1.id};
                s2_v <= 1'b1;
            end else if (s2_adv) begin
                s2_v <= 1'b0;
            end
        end
    end

`ifdef FADD_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (accept && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fadd_rr_sched.sv
// Randomised bench for fadd_rr_sched against an exact-arithmetic adder model and a 2-deep pipe model.
module tb_fadd_rr_sched;
    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct {
        logic [31:0] sum;
        int          id;
        int          edge_n;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fadd_rr_sched_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();
`ifdef FADD_SCHED_STATS_EN
    logic [15:0] op_count;
`endif

    fadd_rr_sched #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FADD_SCHED_STATS_EN
        ,
        .op_count (op_count)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    item_t       q[$];
    int          last, cyc, acc_total, delivered;
    int          p_g;
    logic        p_pop;
    logic [31:0] p_sum;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Exact sum in units of 2^-149, then round-to-nearest-even (finite operands only).
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [279:0] ma, mb, mag, rem, half, one;
        logic [24:0]  keep;
        logic         sr;
        int           hi, sh, ex, ea, eb;
        one = 280'd1;
        ea  = (a[30:23] == 8'd0) ? 0 : int'(a[30:23]) - 1;
        eb  = (b[30:23] == 8'd0) ? 0 : int'(b[30:23]) - 1;
        ma  = 280'({(a[30:23] != 8'd0), a[22:0]}) << ea;
        mb  = 280'({(b[30:23] != 8'd0), b[22:0]}) << eb;
        if (a[31] == b[31]) begin
            mag = ma + mb; sr = a[31];
        end else if (ma >= mb) begin
            mag = ma - mb; sr = (ma == mb) ? 1'b0 : a[31];
        end else begin
            mag = mb - ma; sr = b[31];
        end
        if (mag == 280'd0) return {sr, 31'd0};
        hi = 0;
        for (int i = 0; i < 280; i++) if (mag[i]) hi = i;
        if (hi < 24) return {sr, 7'd0, mag[23:0]};
        sh   = hi - 23;
        keep = 25'(mag >> sh);
        rem  = mag & ((one << sh) - one);
        half = one << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin
            keep = keep >> 1;
            sh++;
        end
        ex = sh + 1;
        if (ex >= 255) return {sr, 8'hFF, 23'd0};
        return {sr, 8'(ex), keep[22:0]};
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int lst);
        for (int k = 1; k <= N; k++) if (v[(lst + k) % N]) return (lst + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 254));
        else e = 8'($urandom_range(120, 134));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic rand_ops(output logic [32*N-1:0] av, output logic [32*N-1:0] bv);
        logic [31:0] x;
        for (int i = 0; i < N; i++) begin
            x = rand_fp();
            av[32*i +: 32] = x;
            if ($urandom_range(0, 3) == 0) bv[32*i +: 32] = {~x[31], x[30:3], 3'($urandom)};
            else bv[32*i +: 32] = rand_fp();
        end
    endtask

    // Drive one cycle's inputs and compare outputs mid-cycle; the model commits in tick_post.
    task automatic tick_pre(input logic [N-1:0] v, input logic [32*N-1:0] a,
                            input logic [32*N-1:0] b, input logic rr);
        logic [N-1:0] exp_rdy;
        logic         exp_vld;
        int           g;
        bus.req_valid  = v;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = rr;
        #3;
        g   = pick(v, last);
        p_g = ((q.size() == 2) && !rr) ? -1 : g;
        exp_rdy = '0;
        if (p_g >= 0) exp_rdy[p_g] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        exp_vld = (q.size() > 0) && (cyc >= q[0].edge_n + 1);
        chk("resp_valid", 32'(bus.resp_valid), 32'(exp_vld));
        if (exp_vld) begin
            chk("resp_data", bus.resp_data, q[0].sum);
            chk("resp_id", 32'(bus.resp_id), 32'(q[0].id));
        end
        p_pop = exp_vld && rr;
        p_sum = (p_g >= 0) ? ref_add(a[32*p_g +: 32], b[32*p_g +: 32]) : 32'd0;
    endtask

    task automatic tick_post();
        item_t it;
        @(posedge clk);
        cyc++;
        if (p_pop) begin
            void'(q.pop_front());
            delivered++;
        end
        if (p_g >= 0) begin
            it.sum = p_sum; it.id = p_g; it.edge_n = cyc;
            q.push_back(it);
            last = p_g;
            acc_total++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick_pre('0, '0, '0, 1'b1);
            tick_post();
        end
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
        q.delete();
        last      = N - 1;
        acc_total = 0;
    endtask

    initial begin
        logic [32*N-1:0] av, bv;
        logic [31:0]     bp_a [3];
        logic [31:0]     bp_b [3];
        int              opi, d0;
        logic            rr;
        rst = 1'b1;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b1;
        last = N - 1; cyc = 0; acc_total = 0; delivered = 0;
        @(posedge clk);
        apply_reset(2);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);

        // All four requesting: strict rotation starting at 0.
        for (int k = 0; k < 8; k++) begin
            rand_ops(av, bv);
            tick_pre(4'b1111, av, bv, 1'b1);
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            if (k >= 2) chk("rr_resp_id", 32'(bus.resp_id), 32'((k - 2) % 4));
            tick_post();
        end
        idle(3);

        // Single op latency with a known sum.
        av = '0; bv = '0;
        av[31:0] = 32'h4A3600CA; bv[31:0] = 32'hC93C97A8;
        tick_pre(4'b0001, av, bv, 1'b1);
        chk("t1_ready", 32'(bus.req_ready), 32'h1);
        tick_post();
        tick_pre('0, '0, '0, 1'b1);
        chk("t1_early", 32'(bus.resp_valid), 32'd0);
        tick_post();
        tick_pre('0, '0, '0, 1'b1);
        chk("t1_valid", 32'(bus.resp_valid), 32'd1);
        chk("t1_data", bus.resp_data, 32'h4A06DAE0);
        chk("t1_id", 32'(bus.resp_id), 32'd0);
        tick_post();
        idle(2);

        // Backpressure: fill both stages, stall, then release.
        bp_a[0] = 32'h498AD804; bp_b[0] = 32'hCA1EF022;
        for (int i = 1; i < 3; i++) begin
            bp_a[i] = rand_fp(); bp_b[i] = rand_fp();
        end
        opi = 0;
        d0  = delivered;
        for (int k = 0; k < 14; k++) begin
            av = '0; bv = '0;
            if (opi < 3) begin
                av[31:0] = bp_a[opi]; bv[31:0] = bp_b[opi];
            end
            tick_pre((opi < 3) ? 4'b0001 : 4'b0000, av, bv, (k >= 7));
            if (k >= 2 && k < 7) begin
                chk("bp_ready", 32'(bus.req_ready), 32'd0);
                chk("bp_hold", bus.resp_data, 32'hC9B30840);
            end
            if (p_g >= 0) opi++;
            tick_post();
        end
        chk("bp_count", 32'(delivered - d0), 32'd3);

        // Sparse requesters 1 and 3.
        for (int k = 0; k < 6; k++) begin
            rand_ops(av, bv);
            av[127:96] = 32'h4AA46873; bv[127:96] = 32'h49CDA038;
            tick_pre(4'b1010, av, bv, 1'b1);
            chk("sp_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
            if (k >= 2 && (k % 2) == 1) begin
                chk("sp_id", 32'(bus.resp_id), 32'd3);
                chk("sp_data", bus.resp_data, 32'h4AD7D081);
            end
            tick_post();
        end
        idle(3);

        // Reset with both stages occupied.
        for (int k = 0; k < 3; k++) begin
            rand_ops(av, bv);
            tick_pre(4'b1111, av, bv, 1'b0);
            tick_post();
        end
        apply_reset(1);
        chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
        rand_ops(av, bv);
        tick_pre(4'b1111, av, bv, 1'b1);
        chk("mid_rst_grant", 32'(bus.req_ready), 32'h1);
        tick_post();
        idle(4);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            rand_ops(av, bv);
            rr = ($urandom_range(0, 3) != 0);
            tick_pre(4'($urandom), av, bv, rr);
            tick_post();
            if ($urandom_range(0, 499) == 0) apply_reset(1);
        end
        idle(3);

`ifdef FADD_SCHED_STATS_EN
        apply_reset(1);
        chk("cnt_rst", 32'(op_count), 32'd0);
        for (int k = 0; k < 70000; k++) begin
            rand_ops(av, bv);
            tick_pre(4'b0001, av, bv, 1'b1);
            tick_post();
            if (k % 10000 == 9999)
                chk("cnt_val", 32'(op_count), (acc_total > 65535) ? 32'hFFFF : 32'(acc_total));
        end
        chk("cnt_sat", 32'(op_count), 32'hFFFF);
        apply_reset(1);
        chk("cnt_clear", 32'(op_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
